// File: rtl/reset_pulse_gen.sv
// Raw reset request generator: fixed-width registered reset pulse, then a quiet holdoff window.
// Power-on and synchronous requests both start pulses; req-initiated pulses are counted (saturating).
module reset_pulse_gen #(
  parameter int ASSERT_CYCLES  = 16,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             rst_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rst_count
);

  localparam int MAX_CYC = (ASSERT_CYCLES > HOLDOFF_CYCLES) ? ASSERT_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0]    ASSERT_LOAD  = CW'(ASSERT_CYCLES - 1);
  localparam logic [CW-1:0]    HOLDOFF_LOAD = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE      = CW'(1);
  localparam logic [CNT_W-1:0] EVT_MAX      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            pend_r, pend_s;
  logic            inc_s;
  logic            done_s;

  // Saturating increment of the event counter; never wraps past all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == EVT_MAX) begin
      sat_inc = val;
    end else begin
      sat_inc = val + CNT_W'(1);
    end
  endfunction

  // State, counter, pending flag and all registered outputs; reset restarts the power-on pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ASSERT;
      cnt_r     <= ASSERT_LOAD;
      pend_r    <= 1'b0;
      rst_out   <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      rst_count <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      rst_out <= (state_s == ASSERT);
      busy    <= (state_s != IDLE);
      done    <= done_s;
      if (inc_s) begin
        rst_count <= sat_inc(rst_count);
      end else begin
        rst_count <= rst_count;
      end
    end
  end

  // Next-state logic; a req in ASSERT wins over cnt==0 so the pulse extends from the last req.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pend_s  = pend_r;
    inc_s   = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        pend_s = 1'b0;
        if (req) begin
          state_s = ASSERT;
          cnt_s   = ASSERT_LOAD;
          inc_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ASSERT: begin
        pend_s = 1'b0;
        if (req) begin
          cnt_s = ASSERT_LOAD;
          inc_s = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = HOLDOFF;
          cnt_s   = HOLDOFF_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLDOFF: begin
        if (cnt_r == CNT_ZERO) begin
          pend_s = 1'b0;
          if (pend_r || req) begin
            state_s = ASSERT;
            cnt_s   = ASSERT_LOAD;
            inc_s   = 1'b1;
          end else begin
            state_s = IDLE;
            done_s  = 1'b1;
          end
        end else begin
          cnt_s  = cnt_r - CNT_ONE;
          pend_s = pend_r | req;
        end
      end
      default: begin
        // Unreachable encoding: park safely in IDLE with a cleared counter.
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        pend_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Randomized and directed scoreboard bench for reset_pulse_gen (8-bit and 2-bit counter variants).
module tb_reset_pulse_gen;

  localparam int A = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       rst_out, busy, done;
  logic [7:0] rst_count;
  logic       rst_out2, busy2, done2;
  logic [1:0] rst_count2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ro;
    logic       bz;
    logic       dn;
    logic [7:0] c8;
    logic [1:0] c2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: remaining pulse cycles and remaining quiet cycles
  int m_a = A;
  int m_h = 0;
  bit m_pend = 1'b0;
  bit m_dn = 1'b0;
  int m_c8 = 0;
  int m_c2 = 0;

  reset_pulse_gen #(.ASSERT_CYCLES(A), .HOLDOFF_CYCLES(H), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req),
    .rst_out(rst_out), .busy(busy), .done(done), .rst_count(rst_count)
  );

  reset_pulse_gen #(.ASSERT_CYCLES(A), .HOLDOFF_CYCLES(H), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .req(req),
    .rst_out(rst_out2), .busy(busy2), .done(done2), .rst_count(rst_count2)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit inc;
    exp_t e;
    inc = 1'b0;
    m_dn = 1'b0;
    if (reset) begin
      m_a = A; m_h = 0; m_pend = 1'b0; m_c8 = 0; m_c2 = 0;
    end else if (m_a > 0) begin
      if (req) begin
        m_a = A; inc = 1'b1;
      end else begin
        m_a = m_a - 1;
        if (m_a == 0) m_h = H;
      end
    end else if (m_h > 0) begin
      if (m_h == 1) begin
        m_h = 0;
        if (m_pend || req) begin
          m_a = A; inc = 1'b1;
        end else begin
          m_dn = 1'b1;
        end
        m_pend = 1'b0;
      end else begin
        m_h = m_h - 1;
        m_pend = m_pend | req;
      end
    end else if (req) begin
      m_a = A; inc = 1'b1;
    end
    if (inc) begin
      if (m_c8 < 255) m_c8 = m_c8 + 1;
      if (m_c2 < 3) m_c2 = m_c2 + 1;
    end
    e.ro = (m_a > 0);
    e.bz = (m_a > 0) || (m_h > 0);
    e.dn = m_dn;
    e.c8 = 8'(m_c8);
    e.c2 = 2'(m_c2);
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compares every presented output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (rst_out !== e.ro || busy !== e.bz || done !== e.dn || rst_count !== e.c8 ||
            rst_out2 !== e.ro || busy2 !== e.bz || done2 !== e.dn || rst_count2 !== e.c2) begin
          errors++;
          $display("FAIL cycle_check t=%0t got ro=%b busy=%b done=%b cnt=%0d | w2 ro=%b busy=%b done=%b cnt=%0d ; expected ro=%b busy=%b done=%b cnt=%0d cnt2=%0d",
                   $time, rst_out, busy, done, rst_count, rst_out2, busy2, done2, rst_count2,
                   e.ro, e.bz, e.dn, e.c8, e.c2);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      req = 1'b0;
    end
  endtask

  task automatic pulse_req();
    @(negedge clk); #1;
    req = 1'b1;
    @(negedge clk); #1;
    req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (rst_out !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rst_count !== 8'd0 || rst_count2 !== 2'd0) begin
      errors++;
      $display("FAIL async_reset got ro=%b busy=%b done=%b cnt=%0d cnt2=%0d expected ro=1 busy=1 done=0 cnt=0 cnt2=0",
               rst_out, busy, done, rst_count, rst_count2);
    end
    repeat (n) @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp2[5];
    int dens;
    exp2 = '{1, 2, 3, 3, 3};

    // Power-on pulse
    repeat (5) @(negedge clk);
    #1;
    reset = 1'b0;
    idle(30);

    // Single request from IDLE
    pulse_req();
    idle(30);

    // Retrigger ten cycles into the pulse
    pulse_req();
    idle(9);
    pulse_req();
    idle(45);

    // Requests during holdoff collapse into one pending pulse
    pulse_req();
    idle(16);
    pulse_req();
    idle(2);
    pulse_req();
    idle(60);

    // Reset mid-pulse restarts the power-on pulse
    pulse_req();
    idle(4);
    do_reset(3);
    idle(40);

    // Isolated requests against the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      pulse_req();
      idle(30);
      checks++;
      if (rst_count2 !== 2'(exp2[i])) begin
        errors++;
        $display("FAIL sat_cnt2 req=%0d got %0d expected %0d", i + 1, rst_count2, exp2[i]);
      end
    end

    // Held-high request: continuous retrigger up to saturation
    do_reset(2);
    idle(30);
    @(negedge clk); #1;
    req = 1'b1;
    repeat (299) @(negedge clk);
    #1;
    req = 1'b0;
    idle(40);
    checks++;
    if (rst_count !== 8'hFF) begin
      errors++;
      $display("FAIL sat_cnt8 got %0d expected 255", rst_count);
    end

    // Random traffic with varying request density and occasional resets
    dens = 10;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) dens = $urandom_range(0, 40);
      @(negedge clk); #1;
      reset = ($urandom_range(0, 199) == 0);
      req = ($urandom_range(0, 99) < dens);
    end
    @(negedge clk); #1;
    reset = 1'b0;
    req = 1'b0;
    idle(40);

    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected at most 1", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
